z80_int_ctrl: RTL and testbench
===============================

Name: z80_int_ctrl

Overview:
- Memory-bus-side interrupt controller for the Z80 core; the responder end of the CPU interrupt protocol.
- Latches peripheral interrupt requests, applies a mask and fixed priority, and drives nINT.
- Answers the M1+IORQ acknowledge cycle with a mode-2 vector on the data bus.
- Snoops opcode fetches for RETI (ED 4D) to retire in-service levels; mask/vector/status registers sit in I/O space.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8); bit 0 = highest priority
IO_BASE, 8'h80, I/O address of register 0; registers occupy IO_BASE..IO_BASE+3
VEC_RESET, 8'h00, reset value of vector base register

Ports:
CLK  in  1  system clock, all logic on rising edge
nRESET  in  1  synchronous, active-low reset
irq_in  in  NUM_SRC  request lines, synchronous to CLK, rising-edge triggered
A  in  8  CPU address bus low byte
D_in  in  8  CPU data bus as driven by CPU/memory
D_out  out  8  data driven onto bus when D_oe=1
D_oe  out  1  data bus output enable
nM1  in  1  CPU M1
nMREQ  in  1  CPU MREQ
nIORQ  in  1  CPU IORQ
nRD  in  1  CPU RD
nWR  in  1  CPU WR
nINT  out  1  interrupt request to CPU, active low

Behaviour:
- Reset (nRESET low at an edge): nINT=1, D_oe=0, D_out=8'h00, MASK=0, VBASE=VEC_RESET, PEND=0, INSV=0, both FSMs idle. Reset mid-acknowledge drops D_oe on the same edge.
- Registers (offset from IO_BASE):
  - 0 MASK (R/W; 1=enabled)
  - 1 VBASE (R/W; only bits [7:4] stored, reads back low nibble 0)
  - 2 PEND (R; write-1-to-clear)
  - 3 INSV (R only; writes ignored)
  - Bits >= NUM_SRC read 0.
- I/O access = nIORQ=0, nM1=1, A in range. Read: D_out=register, D_oe=1 registered while nRD sampled low. Write: D_in captured once, on first edge nWR sampled low.
- Pending: irq_in sampled 1 with previous sample 0 sets PEND bit at that edge. Same-edge set and W1C/ack clear: set wins.
- Priority: winner = lowest index i with PEND[i]&MASK[i]=1 and i < index of lowest set INSV bit (no INSV bit = all eligible). nINT is registered: low on the edge after a winner exists while ACK FSM is IDLE, high otherwise. Latency: irq edge sampled at edge k -> PEND at k -> nINT low after k+1.
- ACK FSM states IDLE, ACK:
  - IDLE->ACK on first edge sampling nM1=0 & nIORQ=0. At that edge: latch winner idx, clear PEND[idx], set INSV[idx], nINT=1.
  - D_out={VBASE[7:4], idx[2:0], 1'b0}, D_oe=1.
  - No winner at ack (spurious): D_out=8'hFF, no PEND/INSV change.
  - ACK->IDLE on first edge sampling nIORQ=1; D_oe=0 at that edge.
  - New requests during ACK set PEND but do not reassert nINT until IDLE.
- RETI snoop states S0, S_ED:
  - Opcode fetch = nM1=0 & nMREQ=0 & nRD=0. Byte = D_in sampled on the last edge before nRD returns high; one byte per fetch.
  - S0: byte ED->S_ED.
  - S_ED: 4D -> clear lowest-index set INSV bit, ->S0; ED -> stay S_ED; other -> S0.
  - RETI with INSV=0: no effect.
- D_oe never asserted outside an I/O read in range or ACK. I/O read and ACK are mutually exclusive by nM1.

Decomposition:
- Package z80_int_ctrl_pkg:
  - register offset constants (REG_MASK=0, REG_VBASE=1, REG_PEND=2, REG_INSV=3)
  - opcode constants OP_ED=8'hED, OP_RETI2=8'h4D
  - enums ack_state_t {IDLE, ACK}, snoop_state_t {S0, S_ED}
- Sub-module z80_int_prio: combinational priority resolver (PEND, MASK, INSV -> valid, idx). Used for both winner selection and lowest-INSV lookup.

Test Plan:
- Reset values: after reset, read IO_BASE+0..3 -> 00, VEC_RESET&F0, 00, 00; nINT=1, D_oe=0 throughout.
- Masked request: MASK=00, pulse irq_in[2] -> PEND reads 04, nINT stays 1. Write MASK=04 -> nINT low two edges later.
- Acknowledge: VBASE=A0, MASK=0F, raise irq_in[1] -> ack cycle returns D=A2. Then PEND=00, INSV=02, nINT=1; D_oe drops the edge nIORQ rises.
- Priority/nesting: INSV=02, pulse irq_in[3] -> nINT stays 1. Pulse irq_in[0] -> nINT low, ack returns A0, INSV=03.
- RETI snoop: fetches ED,4D -> INSV 03->02, pending irq 3 then asserts nINT. Fetches ED,ED,4D also retire; ED,00,4D do not.
- Boundaries: irq edge on same edge as W1C of that bit -> PEND stays set. Ack with PEND=0 -> D=FF, no state change. nRESET low during ACK -> D_oe=0 next edge, INSV=0.

Source files
------------

// File: rtl/z80_int_ctrl_pkg.sv
// Shared constants and types for the Z80 interrupt controller.
//   - register offsets within the controller's 4-byte I/O window
//   - opcode bytes used by the RETI snoop
//   - state types for the acknowledge and RETI-snoop FSMs
//   - helper that builds the mode-2 vector byte
package z80_int_ctrl_pkg;

  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_VBASE = 2'd1;
  localparam logic [1:0] REG_PEND  = 2'd2;
  localparam logic [1:0] REG_INSV  = 2'd3;

  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_RETI2 = 8'h4D;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_t;

  typedef enum logic {
    S0   = 1'b0,
    S_ED = 1'b1
  } snoop_state_t;

  // Mode-2 vector: upper nibble from VBASE, source index in [3:1], bit 0 clear
  // so the CPU always lands on an even table entry.
  function automatic logic [7:0] ack_vector(input logic [3:0] vbase,
                                            input logic [2:0] idx);
    return {vbase, idx, 1'b0};
  endfunction

endpackage

// File: rtl/z80_int_prio.sv
// Fixed-priority resolver for the interrupt controller.
// Index 0 is highest priority. A request is eligible when its req and mask
// bits are set and its index is strictly below the lowest set in-service bit
// (no in-service bit means every index is eligible).
// Also used with mask=all-ones, insv=0 to find the lowest set bit of a vector.
// Ports:
//   i_req   [NUM_SRC] request vector (normally PEND)
//   i_mask  [NUM_SRC] enable vector
//   i_insv  [NUM_SRC] in-service vector, limits eligible indices
//   o_valid           some index is eligible
//   o_idx   [3]       lowest eligible index (0 when none)
module z80_int_prio #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [NUM_SRC-1:0] i_mask,
  input  logic [NUM_SRC-1:0] i_insv,
  output logic               o_valid,
  output logic [2:0]         o_idx
);

  logic               w_seen;
  logic [NUM_SRC-1:0] w_elig;

  always_comb begin
    w_seen = 1'b0;
    w_elig = '0;
    // w_seen turns on at the lowest in-service bit and stays on, blocking
    // that level and everything below it in priority.
    for (int i = 0; i < NUM_SRC; i++) begin
      w_seen    = w_seen | i_insv[i];
      w_elig[i] = i_req[i] & i_mask[i] & ~w_seen;
    end
    o_valid = |w_elig;
    o_idx   = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 mode-2 interrupt controller, bus-responder side.
// Latches rising edges of peripheral requests into PEND, resolves the highest
// priority enabled request that outranks everything in service, drives nINT,
// answers the M1+IORQ acknowledge with a vector, and snoops ED 4D (RETI)
// opcode fetches to retire the lowest-index in-service level.
//
// Bus handshake: the CPU strobes are level signals sampled on every rising
// CLK. An I/O read drives D_out/D_oe on each edge that samples nRD low; an I/O
// write takes D_in once, on the first edge that samples nWR low. An
// acknowledge holds D_oe from the edge that first samples nM1=0 & nIORQ=0 up
// to the edge that samples nIORQ=1.
//
// Ports:
//   CLK, nRESET      clock, synchronous active-low reset
//   irq_in[NUM_SRC]  request lines, rising-edge triggered
//   A[8]             address low byte (register window IO_BASE..IO_BASE+3)
//   D_in[8]          bus data from CPU/memory
//   D_out[8], D_oe   bus data driven by this block and its enable
//   nM1, nMREQ, nIORQ, nRD, nWR   CPU control strobes
//   nINT             interrupt request to CPU, active low
module z80_int_ctrl
  import z80_int_ctrl_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] IO_BASE   = 8'h80,
  parameter logic [7:0] VEC_RESET = 8'h00
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [7:0]         A,
  input  logic [7:0]         D_in,
  output logic [7:0]         D_out,
  output logic               D_oe,
  input  logic               nM1,
  input  logic               nMREQ,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  output logic               nINT
);

  // Register state
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_insv;
  logic [NUM_SRC-1:0] r_irq_prev;
  logic [3:0]         r_vbase;
  logic [7:0]         r_d_out;
  logic               r_d_oe;
  logic               r_nint;
  logic               r_wr_seen;
  logic               r_fetch_act;
  logic [7:0]         r_fetch_byte;
  ack_state_t         r_ack_state;
  snoop_state_t       r_snp_state;

  // Combinational
  ack_state_t         w_ack_next;
  snoop_state_t       w_snp_next;
  logic               w_ack_start;
  logic               w_ack_end;
  logic               w_reti;
  logic [7:0]         w_off;
  logic               w_io_sel;
  logic               w_io_rd;
  logic               w_io_wr;
  logic               w_fetch;
  logic               w_fetch_done;
  logic               w_ack_req;
  logic               w_win_valid;
  logic [2:0]         w_win_idx;
  logic               w_insv_valid;
  logic [2:0]         w_insv_idx;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_pend_w1c;
  logic [NUM_SRC-1:0] w_ack_onehot;
  logic [NUM_SRC-1:0] w_reti_onehot;
  logic [NUM_SRC-1:0] w_pend_next;
  logic [NUM_SRC-1:0] w_insv_next;
  logic [7:0]         w_mask8;
  logic [7:0]         w_pend8;
  logic [7:0]         w_insv8;
  logic [7:0]         w_rd_data;

  // Bus decode. The subtraction makes the window test a single compare.
  assign w_off        = A - IO_BASE;
  assign w_io_sel     = !nIORQ && nM1 && (w_off < 8'd4);
  assign w_io_rd      = w_io_sel && !nRD;
  assign w_io_wr      = w_io_sel && !nWR && !r_wr_seen;
  assign w_fetch      = !nM1 && !nMREQ && !nRD;
  // The fetched byte is the last one sampled while the fetch was active;
  // it is consumed on the first edge after the fetch ends.
  assign w_fetch_done = r_fetch_act && !w_fetch;
  assign w_ack_req    = !nM1 && !nIORQ;

  // Winner: highest-priority enabled pending source outranking in-service.
  z80_int_prio #(.NUM_SRC(NUM_SRC)) u_win (
    .i_req   (r_pend),
    .i_mask  (r_mask),
    .i_insv  (r_insv),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  // Lowest set in-service bit, retired by RETI.
  z80_int_prio #(.NUM_SRC(NUM_SRC)) u_insv (
    .i_req   (r_insv),
    .i_mask  ({NUM_SRC{1'b1}}),
    .i_insv  ({NUM_SRC{1'b0}}),
    .o_valid (w_insv_valid),
    .o_idx   (w_insv_idx)
  );

  // Acknowledge FSM next state
  always_comb begin
    w_ack_next  = r_ack_state;
    w_ack_start = 1'b0;
    w_ack_end   = 1'b0;
    case (r_ack_state)
      IDLE: begin
        if (w_ack_req) begin
          w_ack_next  = ACK;
          w_ack_start = 1'b1;
        end
      end
      ACK: begin
        if (nIORQ) begin
          w_ack_next = IDLE;
          w_ack_end  = 1'b1;
        end
      end
      default: w_ack_next = IDLE;
    endcase
  end

  // RETI snoop FSM next state; ED ED 4D still counts because a repeated ED
  // keeps the FSM armed.
  always_comb begin
    w_snp_next = r_snp_state;
    w_reti     = 1'b0;
    if (w_fetch_done) begin
      case (r_snp_state)
        S0: begin
          if (r_fetch_byte == OP_ED) w_snp_next = S_ED;
        end
        S_ED: begin
          if (r_fetch_byte == OP_RETI2) begin
            w_snp_next = S0;
            w_reti     = 1'b1;
          end else if (r_fetch_byte == OP_ED) begin
            w_snp_next = S_ED;
          end else begin
            w_snp_next = S0;
          end
        end
        default: w_snp_next = S0;
      endcase
    end
  end

  // PEND / INSV update vectors. Rising edges are OR'd in last so a new
  // request beats a same-edge clear.
  always_comb begin
    w_rise        = irq_in & ~r_irq_prev;
    w_pend_w1c    = '0;
    w_ack_onehot  = '0;
    w_reti_onehot = '0;
    if (w_io_wr && (w_off[1:0] == REG_PEND)) w_pend_w1c = D_in[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ack_onehot[i]  = w_ack_start && w_win_valid && (w_win_idx == 3'(i));
      w_reti_onehot[i] = w_reti && w_insv_valid && (w_insv_idx == 3'(i));
    end
    w_pend_next = (r_pend & ~(w_pend_w1c | w_ack_onehot)) | w_rise;
    w_insv_next = (r_insv & ~w_reti_onehot) | w_ack_onehot;
  end

  // Register read mux; bits at or above NUM_SRC read as zero.
  always_comb begin
    w_mask8                = '0;
    w_pend8                = '0;
    w_insv8                = '0;
    w_mask8[NUM_SRC-1:0]   = r_mask;
    w_pend8[NUM_SRC-1:0]   = r_pend;
    w_insv8[NUM_SRC-1:0]   = r_insv;
    case (w_off[1:0])
      REG_MASK:  w_rd_data = w_mask8;
      REG_VBASE: w_rd_data = {r_vbase, 4'h0};
      REG_PEND:  w_rd_data = w_pend8;
      REG_INSV:  w_rd_data = w_insv8;
      default:   w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_mask       <= '0;
      r_pend       <= '0;
      r_insv       <= '0;
      r_irq_prev   <= '0;
      r_vbase      <= VEC_RESET[7:4];
      r_d_out      <= 8'h00;
      r_d_oe       <= 1'b0;
      r_nint       <= 1'b1;
      r_wr_seen    <= 1'b0;
      r_fetch_act  <= 1'b0;
      r_fetch_byte <= 8'h00;
      r_ack_state  <= IDLE;
      r_snp_state  <= S0;
    end else begin
      r_ack_state <= w_ack_next;
      r_snp_state <= w_snp_next;
      r_irq_prev  <= irq_in;
      r_pend      <= w_pend_next;
      r_insv      <= w_insv_next;
      r_wr_seen   <= w_io_sel && !nWR;
      r_fetch_act <= w_fetch;
      if (w_fetch) r_fetch_byte <= D_in;

      if (w_io_wr) begin
        if (w_off[1:0] == REG_MASK)  r_mask  <= D_in[NUM_SRC-1:0];
        if (w_off[1:0] == REG_VBASE) r_vbase <= D_in[7:4];
      end

      // Data bus: acknowledge takes precedence; it cannot overlap an I/O
      // read because the two are separated by nM1.
      if (w_ack_start) begin
        r_d_out <= w_win_valid ? ack_vector(r_vbase, w_win_idx) : 8'hFF;
        r_d_oe  <= 1'b1;
      end else if ((r_ack_state == ACK) && !w_ack_end) begin
        r_d_oe  <= 1'b1;
      end else if (w_io_rd) begin
        r_d_out <= w_rd_data;
        r_d_oe  <= 1'b1;
      end else begin
        r_d_oe  <= 1'b0;
      end

      // nINT is held high for the whole acknowledge, including its first edge.
      r_nint <= !((r_ack_state == IDLE) && !w_ack_start && w_win_valid);
    end
  end

  assign D_out = r_d_out;
  assign D_oe  = r_d_oe;
  assign nINT  = r_nint;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl (NUM_SRC=4, IO_BASE=80, VEC_RESET=00).
module tb_z80_int_ctrl;

  localparam logic [7:0] BASE = 8'h80;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic [3:0] irq_in;
  logic [7:0] A;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;
  logic       nM1, nMREQ, nIORQ, nRD, nWR;
  logic       nINT;

  int n_vec  = 0;
  int n_miss = 0;

  z80_int_ctrl #(
    .NUM_SRC   (4),
    .IO_BASE   (8'h80),
    .VEC_RESET (8'h00)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .irq_in (irq_in),
    .A      (A),
    .D_in   (D_in),
    .D_out  (D_out),
    .D_oe   (D_oe),
    .nM1    (nM1),
    .nMREQ  (nMREQ),
    .nIORQ  (nIORQ),
    .nRD    (nRD),
    .nWR    (nWR),
    .nINT   (nINT)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change 1 ns after a rising edge, outputs sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    A = 8'h00; D_in = 8'h00;
  endtask

  task automatic io_write(input logic [1:0] off, input logic [7:0] data);
    A = BASE + {6'd0, off}; D_in = data; nIORQ = 1'b0; nWR = 1'b0;
    tick();
    tick();
    bus_idle();
    tick();
  endtask

  task automatic read_check(input string tag, input logic [1:0] off, input logic [7:0] exp);
    A = BASE + {6'd0, off}; nIORQ = 1'b0; nRD = 1'b0;
    tick();
    check_vec(tag, D_out, exp);
    check_vec({tag, "_oe"}, {7'd0, D_oe}, 8'h01);
    bus_idle();
    tick();
    check_vec({tag, "_oe_off"}, {7'd0, D_oe}, 8'h00);
  endtask

  task automatic pulse_irq(input int n);
    irq_in[n] = 1'b1;
    tick();
    irq_in[n] = 1'b0;
    tick();
  endtask

  task automatic ack_check(input string tag, input logic [7:0] exp);
    nM1 = 1'b0; nIORQ = 1'b0;
    tick();
    check_vec(tag, D_out, exp);
    check_vec({tag, "_oe"}, {7'd0, D_oe}, 8'h01);
    check_vec({tag, "_nint"}, {7'd0, nINT}, 8'h01);
    tick();
    check_vec({tag, "_oe_hold"}, {7'd0, D_oe}, 8'h01);
    bus_idle();
    tick();
    check_vec({tag, "_oe_drop"}, {7'd0, D_oe}, 8'h00);
  endtask

  task automatic fetch(input logic [7:0] b);
    nM1 = 1'b0; nMREQ = 1'b0; nRD = 1'b0; D_in = b;
    tick();
    tick();
    bus_idle();
    tick();
  endtask

  task automatic check_nint(input string tag, input logic exp);
    check_vec(tag, {7'd0, nINT}, {7'd0, exp});
  endtask

  initial begin
    irq_in = 4'h0;
    bus_idle();
    nRESET = 1'b0;
    repeat (3) tick();
    check_nint("rst_nint", 1'b1);
    check_vec("rst_oe", {7'd0, D_oe}, 8'h00);
    check_vec("rst_dout", D_out, 8'h00);
    nRESET = 1'b1;
    tick();

    // Reset register values
    read_check("rst_mask", 2'd0, 8'h00);
    read_check("rst_vbase", 2'd1, 8'h00);
    read_check("rst_pend", 2'd2, 8'h00);
    read_check("rst_insv", 2'd3, 8'h00);
    check_nint("rst_nint2", 1'b1);

    // Masked request stays pending without nINT
    pulse_irq(2);
    check_nint("mask_nint_hi", 1'b1);
    read_check("mask_pend", 2'd2, 8'h04);
    io_write(2'd0, 8'h04);
    check_nint("unmask_nint_lo", 1'b0);
    io_write(2'd2, 8'h04);
    check_nint("w1c_nint_hi", 1'b1);
    read_check("w1c_pend", 2'd2, 8'h00);

    // Acknowledge
    io_write(2'd1, 8'hA5);
    io_write(2'd0, 8'h0F);
    read_check("vbase_rd", 2'd1, 8'hA0);
    read_check("mask_rd", 2'd0, 8'h0F);
    pulse_irq(1);
    check_nint("irq1_nint", 1'b0);
    ack_check("ack1", 8'hA2);
    read_check("ack1_pend", 2'd2, 8'h00);
    read_check("ack1_insv", 2'd3, 8'h02);
    check_nint("ack1_nint_after", 1'b1);

    // Nesting: level 3 blocked by in-service 1, level 0 preempts
    pulse_irq(3);
    check_nint("nest3_nint", 1'b1);
    read_check("nest3_pend", 2'd2, 8'h08);
    pulse_irq(0);
    check_nint("nest0_nint", 1'b0);
    ack_check("ack0", 8'hA0);
    read_check("ack0_insv", 2'd3, 8'h03);
    read_check("ack0_pend", 2'd2, 8'h08);
    check_nint("ack0_nint_after", 1'b1);

    // INSV is read-only
    io_write(2'd3, 8'h00);
    read_check("insv_ro", 2'd3, 8'h03);

    // RETI snoop: ED 4D retires level 0; level 1 still blocks level 3
    fetch(8'hED);
    fetch(8'h4D);
    read_check("reti1_insv", 2'd3, 8'h02);
    check_nint("reti1_nint", 1'b1);
    // ED ED 4D retires level 1; pending level 3 now raises nINT
    fetch(8'hED);
    fetch(8'hED);
    fetch(8'h4D);
    tick();
    check_nint("reti2_nint", 1'b0);
    read_check("reti2_insv", 2'd3, 8'h00);
    ack_check("ack3", 8'hA6);
    read_check("ack3_insv", 2'd3, 8'h08);
    read_check("ack3_pend", 2'd2, 8'h00);
    // ED 00 4D is not a RETI
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    read_check("noreti_insv", 2'd3, 8'h08);
    fetch(8'hED);
    fetch(8'h4D);
    read_check("reti3_insv", 2'd3, 8'h00);
    // RETI with nothing in service is harmless
    fetch(8'hED);
    fetch(8'h4D);
    read_check("reti_empty_insv", 2'd3, 8'h00);

    // Same-edge set and W1C: set wins
    pulse_irq(2);
    A = BASE + 8'd2; D_in = 8'h04; nIORQ = 1'b0; nWR = 1'b0; irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    bus_idle();
    tick();
    read_check("race_pend", 2'd2, 8'h04);
    check_nint("race_nint", 1'b0);
    io_write(2'd2, 8'h04);
    read_check("race_clr_pend", 2'd2, 8'h00);
    check_nint("race_clr_nint", 1'b1);

    // Spurious acknowledge
    ack_check("ack_spur", 8'hFF);
    read_check("spur_pend", 2'd2, 8'h00);
    read_check("spur_insv", 2'd3, 8'h00);

    // Reset in the middle of an acknowledge
    pulse_irq(0);
    check_nint("rstack_nint_lo", 1'b0);
    nM1 = 1'b0; nIORQ = 1'b0;
    tick();
    check_vec("rstack_vec", D_out, 8'hA0);
    check_vec("rstack_oe_on", {7'd0, D_oe}, 8'h01);
    nRESET = 1'b0;
    tick();
    check_vec("rstack_oe_off", {7'd0, D_oe}, 8'h00);
    check_nint("rstack_nint", 1'b1);
    nRESET = 1'b1;
    bus_idle();
    tick();
    check_vec("rstack_oe_idle", {7'd0, D_oe}, 8'h00);
    read_check("rstack_insv", 2'd3, 8'h00);
    read_check("rstack_pend", 2'd2, 8'h00);
    read_check("rstack_mask", 2'd0, 8'h00);
    read_check("rstack_vbase", 2'd1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
